flash_spi_bridge: RTL and testbench

FLASH_SPI_BRIDGE -- requirements
Module: flash_spi_bridge

---
 rtl/flash_spi_pkg.sv | 36 +++
 rtl/spi_shift8.sv | 57 +++++
 rtl/flash_spi_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_flash_spi_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_spi_pkg.sv
// flash_spi_pkg
//   Shared types and constants for the CPU-to-SPI-flash bridge.
//   - state_t     : bridge sequencer states
//   - DEF_CMD_*   : default flash opcodes (read, page program, write enable)
//   - ADDR_PAD    : upper byte of the 24-bit flash address (CPU supplies 16 bits)
//   - addr_byte() : selects one byte of the padded 24-bit address, MSB byte first
package flash_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WREN,
        GAP,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam logic [7:0] DEF_CMD_READ  = 8'h03;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h02;
    localparam logic [7:0] DEF_CMD_WREN  = 8'h06;

    // The flash takes 24-bit addresses; the CPU window only reaches the low 64 KiB.
    localparam logic [7:0] ADDR_PAD = 8'h00;

    function automatic logic [7:0] addr_byte(input logic [15:0] a, input logic [1:0] idx);
        logic [23:0] full;
        full = {ADDR_PAD, a};
        case (idx)
            2'd0:    return full[23:16];
            2'd1:    return full[15:8];
            default: return full[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_shift8.sv
// spi_shift8
//   8-bit SPI byte shifter, MSB first.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     load        : load load_data and restart the bit counter (wins over shift)
//     load_data   : byte to transmit
//     sample      : SCK rising edge strobe, captures miso
//     shift       : SCK falling edge strobe, advances the register by one bit
//     miso        : serial input
//     mosi        : serial output (register MSB)
//     data        : register contents (received byte after eight shifts)
//     done        : one-cycle pulse on the eighth shift of a byte
module spi_shift8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       sample,
    input  logic       shift,
    input  logic       miso,
    output logic       mosi,
    output logic [7:0] data,
    output logic       done
);

    logic [7:0] sr;
    logic [2:0] cnt;
    logic       rx_bit;

    // MISO is captured on the rising edge but only enters the register on the
    // following falling edge, so MOSI and the received data share one shifter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= 8'h00;
            cnt    <= 3'd0;
            rx_bit <= 1'b0;
        end else if (load) begin
            sr  <= load_data;
            cnt <= 3'd0;
        end else begin
            if (sample) begin
                rx_bit <= miso;
            end
            if (shift) begin
                sr  <= {sr[6:0], rx_bit};
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign mosi = sr[7];
    assign data = sr;
    assign done = shift & (cnt == 3'd7);

endmodule

// File: rtl/flash_spi_bridge.sv
// flash_spi_bridge
//   Turns CPU read/write strobes into SPI-flash transactions (mode 0).
//   Read : CMD_READ, 24-bit address, 8 MISO bits -> rdata.
//   Write: CMD_WREN frame, CS gap, CMD_WRITE, 24-bit address, wdata.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     oe_, we_   : CPU read / write strobes, active low (both low = write)
//     addr       : 16-bit byte address, latched at acceptance
//     wdata      : write byte, latched at acceptance
//     rdata      : last read byte
//     rdata_en   : drive enable for rdata onto the CPU data bus
//     ready      : high when idle
//     spi_sck, spi_cs_n, spi_mosi, spi_miso : SPI flash pins
module flash_spi_bridge
    import flash_spi_pkg::*;
#(
    parameter int unsigned SCK_DIV   = 2,
    parameter logic [7:0]  CMD_READ  = DEF_CMD_READ,
    parameter logic [7:0]  CMD_WRITE = DEF_CMD_WRITE,
    parameter logic [7:0]  CMD_WREN  = DEF_CMD_WREN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        oe_,
    input  logic        we_,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_en,
    output logic        ready,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t      state, state_d;
    logic [7:0]  div_cnt, div_d;
    logic [1:0]  byte_cnt, byte_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic        ready_q, ready_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        last_rd, last_rd_d;
    logic        is_wr, is_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        oe_hist, we_hist;

    logic        in_frame, tick, accept;
    logic        load, shift, sample, sh_done;
    logic [7:0]  load_data, sh_data;

    // A half-period of SCK is SCK_DIV clk cycles; tick marks its last cycle.
    assign tick     = (div_cnt == 8'(SCK_DIV - 1));
    assign in_frame = (state == WREN) || (state == CMD) || (state == ADDR) || (state == DATA);
    assign shift    = in_frame & tick & sck_q;
    assign sample   = in_frame & tick & ~sck_q;

    // Falling-edge detect: both strobes high on the previous edge, one low now.
    assign accept = oe_hist & we_hist & (~oe_ | ~we_);

    spi_shift8 u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .sample    (sample),
        .shift     (shift),
        .miso      (spi_miso),
        .mosi      (spi_mosi),
        .data      (sh_data),
        .done      (sh_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            byte_cnt <= 2'd0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            ready_q  <= 1'b1;
            rdata_q  <= 8'h00;
            last_rd  <= 1'b0;
            is_wr    <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            oe_hist  <= 1'b1;
            we_hist  <= 1'b1;
        end else begin
            state    <= state_d;
            div_cnt  <= div_d;
            byte_cnt <= byte_d;
            sck_q    <= sck_d;
            cs_n_q   <= cs_n_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            last_rd  <= last_rd_d;
            is_wr    <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            oe_hist  <= oe_;
            we_hist  <= we_;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_d   = state;
        div_d     = div_cnt;
        byte_d    = byte_cnt;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        ready_d   = ready_q;
        rdata_d   = rdata_q;
        last_rd_d = last_rd;
        is_wr_d   = is_wr;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        load      = 1'b0;
        load_data = 8'h00;

        case (state)
            IDLE: begin
                div_d  = 8'd0;
                byte_d = 2'd0;
                if (accept) begin
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    addr_d  = addr;
                    wdata_d = wdata;
                    is_wr_d = ~we_;
                    load    = 1'b1;
                    if (!we_) begin
                        state_d   = WREN;
                        load_data = CMD_WREN;
                    end else begin
                        state_d   = CMD;
                        load_data = CMD_READ;
                    end
                end
            end

            WREN, CMD, ADDR, DATA: begin
                div_d = tick ? 8'd0 : div_cnt + 8'd1;
                if (tick) begin
                    sck_d = ~sck_q;
                end
                // Byte boundaries fall on the eighth SCK falling edge; the next
                // byte is loaded there so its MSB is set up a half-period early.
                if (sh_done) begin
                    if (state == WREN) begin
                        state_d = GAP;
                        byte_d  = 2'd0;
                    end else if (state == CMD) begin
                        state_d   = ADDR;
                        byte_d    = 2'd0;
                        load      = 1'b1;
                        load_data = addr_byte(addr_q, 2'd0);
                    end else if (state == ADDR) begin
                        load = 1'b1;
                        if (byte_cnt == 2'd2) begin
                            state_d   = DATA;
                            load_data = is_wr ? wdata_q : 8'h00;
                        end else begin
                            byte_d    = byte_cnt + 2'd1;
                            load_data = addr_byte(addr_q, byte_cnt + 2'd1);
                        end
                    end else begin
                        state_d = DONE;
                        byte_d  = 2'd0;
                    end
                end
            end

            // Four half-periods: CS held low for two after WREN, then high for two.
            GAP: begin
                div_d = tick ? 8'd0 : div_cnt + 8'd1;
                if (tick) begin
                    byte_d = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd1) begin
                        cs_n_d = 1'b1;
                    end
                    if (byte_cnt == 2'd3) begin
                        state_d   = CMD;
                        cs_n_d    = 1'b0;
                        load      = 1'b1;
                        load_data = CMD_WRITE;
                    end
                end
            end

            // Two-cycle CS hold after the last falling edge, then release.
            DONE: begin
                byte_d = byte_cnt + 2'd1;
                if (byte_cnt == 2'd1) begin
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    cs_n_d    = 1'b1;
                    last_rd_d = ~is_wr;
                    if (!is_wr) begin
                        rdata_d = sh_data;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign ready    = ready_q;
    assign rdata    = rdata_q;
    // Only drive the CPU bus for a pure read cycle after a completed read.
    assign rdata_en = ready_q & ~oe_ & we_ & last_rd;

endmodule

// File: tb/tb_flash_spi_bridge.sv
// tb_flash_spi_bridge
//   Directed bench for flash_spi_bridge with a transaction-level model
//   (latency counter, expected rdata/rdata_en) compared every cycle, and an
//   SPI flash monitor/responder that logs MOSI frames and answers reads.
module tb_flash_spi_bridge;

    localparam int D      = 2;
    localparam int RD_LAT = 2 + 80 * D;
    localparam int WR_LAT = 2 + 100 * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        oe_ = 1'b1;
    logic        we_ = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        rdata_en;
    logic        ready;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    flash_spi_bridge #(
        .SCK_DIV   (D),
        .CMD_READ  (8'h03),
        .CMD_WRITE (8'h02),
        .CMD_WREN  (8'h06)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .oe_      (oe_),
        .we_      (we_),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_en (rdata_en),
        .ready    (ready),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- transaction-level model ----------------
    logic [7:0] miso_byte = 8'h00;
    int         m_cnt = 0;
    logic       m_wr = 1'b0;
    logic       m_last_rd = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_oe_q = 1'b1;
    logic       m_we_q = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     = 0;
            m_wr      = 1'b0;
            m_last_rd = 1'b0;
            m_rdata   = 8'h00;
            m_oe_q    = 1'b1;
            m_we_q    = 1'b1;
        end else begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    if (!m_wr) m_rdata = miso_byte;
                    m_last_rd = !m_wr;
                end
            end else if (m_oe_q && m_we_q && (!oe_ || !we_)) begin
                m_wr  = !we_;
                m_cnt = m_wr ? WR_LAT : RD_LAT;
            end
            m_oe_q = oe_;
            m_we_q = we_;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic en_seen = 1'b0;

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            logic exp_ready;
            exp_ready = (m_cnt == 0);
            check("ready", ready, exp_ready);
            check("rdata", rdata, m_rdata);
            check("rdata_en", rdata_en, exp_ready && !oe_ && we_ && m_last_rd);
            if (exp_ready) begin
                check("idle_cs_n", spi_cs_n, 1'b1);
                check("idle_sck", spi_sck, 1'b0);
            end
            if (rdata_en) en_seen = 1'b1;
        end
    end

    // ---------------- SPI flash monitor / responder ----------------
    logic [63:0] fdata [8];
    int          fbits [8];
    int          nframes = 0;
    int          last_gap = -1;
    int          rise_cyc = 0;
    logic [63:0] cur = 64'd0;
    int          bits = 0;
    logic        active = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;

    always @(posedge clk) begin
        #1;
        if (prev_cs && !spi_cs_n) begin
            active   = 1'b1;
            bits     = 0;
            cur      = 64'd0;
            spi_miso = 1'b0;
            if (nframes > 0) last_gap = cyc - rise_cyc;
        end
        if (!prev_cs && spi_cs_n && active) begin
            if (nframes < 8) begin
                fdata[nframes] = cur;
                fbits[nframes] = bits;
            end
            nframes++;
            rise_cyc = cyc;
            active   = 1'b0;
        end
        if (!spi_cs_n && !prev_sck && spi_sck) begin
            cur  = {cur[62:0], spi_mosi};
            bits = bits + 1;
        end
        if (!spi_cs_n && prev_sck && !spi_sck) begin
            if (bits >= 32 && bits < 40) spi_miso = miso_byte[39 - bits];
            else spi_miso = 1'b0;
        end
        prev_cs  = spi_cs_n;
        prev_sck = spi_sck;
    end

    // ---------------- stimulus helpers ----------------
    int t_acc = 0;

    task automatic clear_log();
        nframes  = 0;
        last_gap = -1;
        for (int i = 0; i < 8; i++) begin
            fdata[i] = 64'd0;
            fbits[i] = 0;
        end
    endtask

    task automatic start(input logic oe_v, input logic we_v);
        @(negedge clk);
        oe_ = oe_v;
        we_ = we_v;
        @(posedge clk);
        #1;
        t_acc = cyc;
    endtask

    task automatic wait_ready(input string name, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < exp_lat + 50; i++) begin
            @(posedge clk);
            #2;
            if (ready) begin
                lat = cyc - t_acc;
                break;
            end
        end
        check(name, lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_rdata_en", rdata_en, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Read 0x1234 -> A5, oe_ held low across completion, addr changed mid-frame.
        clear_log();
        miso_byte = 8'hA5;
        addr = 16'h1234;
        start(1'b0, 1'b1);
        @(negedge clk);
        addr = 16'hFFFF;
        wait_ready("rd_latency", 162);
        check("rd_rdata", rdata, 8'hA5);
        check("rd_rdata_en", rdata_en, 1'b1);
        check("rd_frames", nframes, 1);
        check("rd_bits", fbits[0], 40);
        check("rd_mosi", fdata[0][39:8], 32'h03001234);
        repeat (20) @(posedge clk);
        #2;
        check("held_ready", ready, 1'b1);
        check("held_frames", nframes, 1);
        @(negedge clk);
        oe_ = 1'b1;
        #1 check("rd_en_drop", rdata_en, 1'b0);

        // Write 0x8001 <- 3C, inputs changed after acceptance.
        clear_log();
        addr = 16'h8001;
        wdata = 8'h3C;
        start(1'b1, 1'b0);
        @(negedge clk);
        we_ = 1'b1;
        addr = 16'h0000;
        wdata = 8'hFF;
        wait_ready("wr_latency", 202);
        check("wr_frames", nframes, 2);
        check("wr_wren_bits", fbits[0], 8);
        check("wr_wren", fdata[0][7:0], 8'h06);
        check("wr_gap", last_gap, 4);
        check("wr_bits", fbits[1], 40);
        check("wr_mosi", fdata[1][39:0], 40'h020080013C);
        check("wr_rdata_kept", rdata, 8'hA5);

        // Simultaneous strobes -> write only, never drive the bus.
        clear_log();
        en_seen = 1'b0;
        addr = 16'h0042;
        wdata = 8'h99;
        start(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        oe_ = 1'b1;
        we_ = 1'b1;
        wait_ready("both_latency", WR_LAT);
        check("both_frames", nframes, 2);
        check("both_wren", fdata[0][7:0], 8'h06);
        check("both_mosi", fdata[1][39:0], 40'h0200004299);
        check("both_en_seen", en_seen, 1'b0);
        check("both_rdata", rdata, 8'hA5);

        // Busy request ignored.
        clear_log();
        miso_byte = 8'h5A;
        addr = 16'h00FF;
        start(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        oe_ = 1'b1;
        repeat (17) @(negedge clk);
        oe_ = 1'b0;
        repeat (2) @(negedge clk);
        oe_ = 1'b1;
        wait_ready("busy_latency", RD_LAT);
        check("busy_frames", nframes, 1);
        check("busy_mosi", fdata[0][39:8], 32'h030000FF);
        check("busy_rdata", rdata, 8'h5A);
        repeat (10) @(posedge clk);
        #2 check("busy_no_second", nframes, 1);

        // Reset during the address phase of a read.
        clear_log();
        miso_byte = 8'hC3;
        addr = 16'h4321;
        start(1'b0, 1'b1);
        @(negedge clk);
        oe_ = 1'b1;
        repeat (60) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_ready", ready, 1'b1);
        check("abort_rdata", rdata, 8'h00);
        check("abort_sck", spi_sck, 1'b0);
        check("abort_rdata_en", rdata_en, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        start(1'b0, 1'b1);
        @(negedge clk);
        oe_ = 1'b1;
        wait_ready("post_rst_latency", RD_LAT);
        check("post_rst_rdata", rdata, 8'hC3);
        check("post_rst_frames", nframes, 1);
        check("post_rst_mosi", fdata[0][39:8], 32'h03004321);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
